// File: rtl/ac_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ac_exec_ctrl
// Purpose  : Multi-cycle sequencer for the Basic Computer accumulator path.
//            Owns AC, DR and E. Accepts one command at a time, fetches a
//            memory operand into DR when needed, then drives the external
//            ALU and commits its result.
// Revision : 1.0 - initial release
// ============================================================================
module ac_exec_ctrl #(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [W-1:0]  mem_rdata,
  output logic [2:0]    alu_op,
  output logic [W-1:0]  alu_ac,
  output logic [W-1:0]  alu_dr,
  output logic          alu_e,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_co,
  input  logic          alu_ovf,
  output logic [W-1:0]  ac,
  output logic          e,
  output logic          ovf,
  output logic          done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_CMA = 3'b011;
  localparam logic [2:0] OP_CIR = 3'b100;
  localparam logic [2:0] OP_CIL = 3'b101;
  localparam logic [2:0] OP_CLA = 3'b110;
  localparam logic [2:0] OP_CME = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [W-1:0]    ac_q, ac_d;
  logic [W-1:0]    dr_q, dr_d;
  logic            e_q, e_d;
  logic            ovf_q, ovf_d;

  // ALU operands mirror the architectural registers at all times.
  assign alu_ac   = ac_q;
  assign alu_dr   = dr_q;
  assign alu_e    = e_q;
  assign alu_op   = alu_op_q;
  assign mem_addr = addr_q;
  assign ac       = ac_q;
  assign e        = e_q;
  assign ovf      = ovf_q;

  // State and register file; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      alu_op_q <= '0;
      ac_q     <= '0;
      dr_q     <= '0;
      e_q      <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      alu_op_q <= alu_op_d;
      ac_q     <= ac_d;
      dr_q     <= dr_d;
      e_q      <= e_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, handshake outputs and register updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    alu_op_d  = alu_op_q;
    ac_d      = ac_q;
    dr_d      = dr_q;
    e_d       = e_q;
    ovf_d     = ovf_q;
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Held low while reset is asserted so nothing is offered too early.
        cmd_ready = rst_n;
        if (cmd_valid && cmd_ready) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          // CLA and CME do not use the ALU result; park the ALU on pass-DR.
          alu_op_d = (cmd_op <= OP_CIL) ? cmd_op : OP_LDA;
          state_d  = (cmd_op <= OP_LDA) ? S_FETCH : S_EXEC;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          dr_d    = mem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            ac_d  = alu_result;
            e_d   = alu_co;
            ovf_d = alu_ovf;
          end
          OP_AND, OP_LDA, OP_CMA: ac_d = alu_result;
          OP_CIR: begin
            ac_d = alu_result;
            e_d  = ac_q[0];
          end
          OP_CIL: begin
            ac_d = alu_result;
            e_d  = ac_q[W-1];
          end
          OP_CLA: ac_d = '0;
          OP_CME: e_d  = ~e_q;
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ac_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac_exec_ctrl
// Purpose  : Self-checking bench for ac_exec_ctrl with a behavioural ALU,
//            a memory responder and a command-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ac_exec_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [2:0]  alu_op;
  logic [15:0] alu_ac;
  logic [15:0] alu_dr;
  logic        alu_e;
  logic [15:0] alu_result;
  logic        alu_co;
  logic        alu_ovf;
  logic [15:0] ac;
  logic        e;
  logic        ovf;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int last_lat;

  // Reference state
  int unsigned m_ac, m_dr;
  bit          m_e, m_ovf;

  ac_exec_ctrl #(.W(16), .AW(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .alu_op     (alu_op),
    .alu_ac     (alu_ac),
    .alu_dr     (alu_dr),
    .alu_e      (alu_e),
    .alu_result (alu_result),
    .alu_co     (alu_co),
    .alu_ovf    (alu_ovf),
    .ac         (ac),
    .e          (e),
    .ovf        (ovf),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Basic Computer ALU sitting beside the controller.
  logic [16:0] t_sum;
  always_comb begin
    t_sum      = {1'b0, alu_ac} + {1'b0, alu_dr};
    alu_result = alu_dr;
    alu_co     = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_result = t_sum[15:0];
        alu_co     = t_sum[16];
        alu_ovf    = (alu_ac[15] == alu_dr[15]) && (t_sum[15] != alu_ac[15]);
      end
      3'd1:    alu_result = alu_ac & alu_dr;
      3'd2:    alu_result = alu_dr;
      3'd3:    alu_result = ~alu_ac;
      3'd4:    alu_result = {alu_e, alu_ac[15:1]};
      3'd5:    alu_result = {alu_ac[14:0], alu_e};
      default: alu_result = alu_dr;
    endcase
  end

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Command-level semantics computed with plain integer arithmetic.
  task automatic ref_apply(input int op, input int unsigned data);
    int a, b, r;
    int unsigned s;
    case (op)
      0: begin
        m_dr  = data;
        s     = m_ac + data;
        a     = (m_ac >= 32768) ? int'(m_ac) - 65536 : int'(m_ac);
        b     = (data >= 32768) ? int'(data) - 65536 : int'(data);
        r     = a + b;
        m_ovf = (r > 32767) || (r < -32768);
        m_e   = (s >= 65536);
        m_ac  = s % 65536;
      end
      1: begin m_dr = data; m_ac = m_ac & data; end
      2: begin m_dr = data; m_ac = data; end
      3: m_ac = 65535 - m_ac;
      4: begin
        b    = int'(m_ac % 2);
        m_ac = (m_ac / 2) + (m_e ? 32768 : 0);
        m_e  = (b != 0);
      end
      5: begin
        b    = (m_ac >= 32768) ? 1 : 0;
        m_ac = ((m_ac * 2) % 65536) + (m_e ? 1 : 0);
        m_e  = (b != 0);
      end
      6: m_ac = 0;
      default: m_e = ~m_e;
    endcase
  endtask

  // Issue one command and follow it to completion. Starts and ends just
  // after a rising edge with the DUT idle. d = FETCH cycles before ack.
  task automatic do_cmd(input int op, input logic [11:0] addr,
                        input logic [15:0] data, input int d);
    int  w, k, lat;
    bit  is_mem, seen;
    logic [15:0] x_dr, x_ac;
    cmd_op    = op[2:0];
    cmd_addr  = addr;
    cmd_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk_val("accept_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_addr  = 12'($urandom);
    is_mem = (op <= 2);
    lat    = is_mem ? d + 3 : 2;
    x_dr   = is_mem ? data : 16'(m_dr);
    x_ac   = 16'(m_ac);
    seen   = 0;
    k      = 1;
    while (!seen && k <= 30) begin
      if (is_mem && k == d + 1) begin
        mem_ack = 1'b1; mem_rdata = data;
      end else if ((!is_mem || k > d + 1) && ($urandom % 4 == 0)) begin
        mem_ack = 1'b1; mem_rdata = 16'($urandom);
      end else begin
        mem_ack = 1'b0; mem_rdata = 16'($urandom);
      end
      @(negedge clk);
      if (is_mem && k <= d + 1) begin
        chk_val("fetch_req", mem_req, 1);
        chk_val("fetch_addr", mem_addr, addr);
      end else begin
        chk_val("no_req", mem_req, 0);
      end
      chk_val("busy_not_ready", cmd_ready, 0);
      if (k == lat - 1) begin
        chk_val("exec_alu_op", alu_op, (op <= 5) ? op : 2);
        chk_val("exec_alu_ac", alu_ac, x_ac);
        chk_val("exec_alu_dr", alu_dr, x_dr);
      end
      if (done) seen = 1;
      else      k++;
      @(posedge clk); #1;
    end
    mem_ack  = 1'b0;
    last_lat = k;
    chk_val("latency", k, lat);
    ref_apply(op, data);
    @(negedge clk);
    chk_val("done_pulse_1cyc", done, 0);
    chk_val("idle_ready", cmd_ready, 1);
    chk_val("ac", ac, m_ac);
    chk_val("e", e, m_e);
    chk_val("ovf", ovf, m_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    int dones, k_ready;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    m_ac = 0; m_dr = 0; m_e = 0; m_ovf = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_ready_low", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_val("rst_ready", cmd_ready, 1);
    chk_val("rst_ac", ac, 0);
    chk_val("rst_e", e, 0);
    chk_val("rst_ovf", ovf, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_req", mem_req, 0);
    chk_val("rst_dr", alu_dr, 0);
    @(posedge clk); #1;

    // CLA then LDA with ack in the second FETCH cycle
    do_cmd(6, 12'h000, 16'h0000, 0);
    do_cmd(2, 12'h010, 16'h1234, 1);
    chk_val("lda_ac", ac, 16'h1234);
    chk_val("lda_lat4", last_lat, 4);

    // ADD wrap and signed overflow
    do_cmd(2, 12'h020, 16'hFFFF, 0);
    do_cmd(0, 12'h021, 16'h0001, 2);
    chk_val("add_wrap_ac", ac, 16'h0000);
    chk_val("add_wrap_e", e, 1);
    chk_val("add_wrap_ovf", ovf, 0);
    do_cmd(2, 12'h022, 16'h7FFF, 0);
    do_cmd(0, 12'h023, 16'h0001, 0);
    chk_val("add_ovf_ac", ac, 16'h8000);
    chk_val("add_ovf_e", e, 0);
    chk_val("add_ovf_ovf", ovf, 1);

    // Rotates and CME
    do_cmd(2, 12'h030, 16'h8001, 0);
    do_cmd(4, 12'h000, 16'h0000, 0);
    chk_val("cir_ac", ac, 16'h4000);
    chk_val("cir_e", e, 1);
    do_cmd(5, 12'h000, 16'h0000, 0);
    chk_val("cil_ac", ac, 16'h8001);
    chk_val("cil_e", e, 0);
    do_cmd(7, 12'h000, 16'h0000, 0);
    chk_val("cme_e", e, 1);
    chk_val("cme_ac", ac, 16'h8001);

    // CMA then AND
    do_cmd(2, 12'h040, 16'h0F0F, 0);
    do_cmd(3, 12'h000, 16'h0000, 0);
    chk_val("cma_ac", ac, 16'hF0F0);
    chk_val("cma_lat2", last_lat, 2);
    do_cmd(1, 12'h041, 16'hFF00, 1);
    chk_val("and_ac", ac, 16'hF000);

    // Held cmd_valid: LDA then CME queued by the requester
    cmd_op = 3'd2; cmd_addr = 12'h055; cmd_valid = 1'b1;
    @(negedge clk);
    chk_val("b2b_ready0", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_op = 3'd7;
    dones = 0; k_ready = 0;
    for (int k = 1; k <= 12; k++) begin
      mem_ack   = (k == 1);
      mem_rdata = 16'hA5A5;
      if (k == 5) cmd_valid = 1'b0;
      @(negedge clk);
      if (done) dones++;
      if (done && dones == 1) chk_val("b2b_first_done_cyc", k, 3);
      if (cmd_ready && k_ready == 0) k_ready = k;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    ref_apply(2, 16'hA5A5);
    ref_apply(7, 0);
    chk_val("b2b_ready_cyc", k_ready, 4);
    chk_val("b2b_done_count", dones, 2);
    chk_val("b2b_ac", ac, m_ac);
    chk_val("b2b_e", e, m_e);

    // Randomized commands against the reference model
    for (int i = 0; i < 150; i++) begin
      int unsigned dat;
      case ($urandom_range(0, 5))
        0:       dat = 16'hFFFF;
        1:       dat = 16'h0001;
        2:       dat = 16'h7FFF;
        default: dat = $urandom_range(0, 65535);
      endcase
      do_cmd($urandom_range(0, 7), 12'($urandom), 16'(dat), $urandom_range(0, 3));
    end

    // Reset in the middle of a fetch
    do_cmd(2, 12'h060, 16'hBEEF, 0);
    if (!e) do_cmd(7, 12'h000, 16'h0000, 0);
    cmd_op = 3'd2; cmd_addr = 12'h061; cmd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk_val("mid_fetch_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("arst_req", mem_req, 0);
    chk_val("arst_ac", ac, 0);
    chk_val("arst_dr", alu_dr, 0);
    chk_val("arst_e", e, 0);
    chk_val("arst_ovf", ovf, 0);
    chk_val("arst_ready", cmd_ready, 0);
    m_ac = 0; m_dr = 0; m_e = 0; m_ovf = 0;
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dones++;
      chk_val("post_rst_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    chk_val("post_rst_no_done", dones, 0);
    chk_val("post_rst_ac", ac, 0);
    chk_val("post_rst_dr", alu_dr, 0);
    @(posedge clk); #1;
    do_cmd(7, 12'h000, 16'h0000, 0);
    chk_val("post_rst_cme_e", e, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time guard
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
